// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: each 32-bit load/store runs as two 16-bit phases on an async SRAM, and ready freezes the pipeline until the access ends.
// Optional stall counter is enabled by defining MEM_SRAM_STALL_CNT_EN.
module mem_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic [31:0]        stall_cycles
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [3:0] LAST   = 4'(WAIT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [29:0]        word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [15:0]        rdata_lo_q, rdata_lo_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        dq_o_q, dq_o_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;

  // Byte offset from the SRAM window; the low two bits select a byte and are dropped.
  logic [31:0] offset;
  logic [29:0] word_in;
  logic        unused_byte_sel;
  assign offset          = address - 32'(BASE_ADDR);
  assign word_in         = offset[31:2];
  assign unused_byte_sel = ^offset[1:0];

  function automatic logic [SRAM_AW-1:0] hw_addr(input logic [29:0] w, input logic hi);
    logic [30:0] full;
    full = {w, hi};
    return full[SRAM_AW-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    rdata_lo_d  = rdata_lo_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    dq_o_d      = dq_o_q;
    dq_oe_d     = dq_oe_q;
    we_n_d      = we_n_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en || rd_en) begin
          state_d     = S_LOW;
          cnt_d       = 4'd0;
          op_wr_d     = wr_en;
          word_d      = word_in;
          wdata_d     = wdata;
          sram_addr_d = hw_addr(word_in, 1'b0);
          dq_o_d      = wr_en ? wdata[15:0] : dq_o_q;
          dq_oe_d     = wr_en;
          we_n_d      = !wr_en;
        end
      end
      S_LOW: begin
        if (cnt_q == LAST) begin
          state_d     = S_HIGH;
          cnt_d       = 4'd0;
          sram_addr_d = hw_addr(word_q, 1'b1);
          if (op_wr_q) dq_o_d = wdata_q[31:16];
          else         rdata_lo_d = sram_dq_i;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
          dq_oe_d = 1'b0;
          we_n_d  = 1'b1;
          if (!op_wr_q) rdata_d = {sram_dq_i, rdata_lo_q};
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rdata_lo_q  <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      rdata_lo_q  <= rdata_lo_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  assign ready      = (state_q == S_IDLE && !rd_en && !wr_en) || (state_q == S_DONE);
  assign rdata      = rdata_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_we_n  = we_n_q;

`ifdef MEM_SRAM_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        stall_q <= '0;
    else if (!ready) stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: stimulus pushes expected rdata per access, a monitor pops on each completion.
module tb_mem_sram_ctrl;
  localparam int AW = 18;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en, wr_en;
  logic [31:0]   address, wdata, rdata, stall_cycles;
  logic          ready, sram_dq_oe, sram_we_n;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o, sram_dq_i;

  mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(WC), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // SRAM model: write strobe sampled on the clock edge, read is combinational.
  logic [15:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
  assign sram_dq_i = mem[sram_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  logic        prev_ready = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b1;
    end else begin
      if (ready && !prev_ready) begin
        if (exp_q.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
        else check("sb_rdata", rdata, exp_q.pop_front());
      end
      prev_ready = ready;
    end
  end

  logic [AW-1:0] tr_addr [0:15];
  logic [15:0]   tr_dq   [0:15];
  logic          tr_wen  [0:15];
  int            low_cnt;

  // Issue one access, wait (bounded) for ready, then drop the request after the completing edge.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd);
    int k;
    exp_q.push_back(exp_rd);
    wr_en = wr; rd_en = rd; address = a; wdata = d;
    k = 0;
    forever begin
      @(negedge clk);
      if (k < 16) begin
        tr_addr[k] = sram_addr; tr_dq[k] = sram_dq_o; tr_wen[k] = sram_we_n;
      end
      if (ready) break;
      k++;
      if (k > 100) begin
        check("ready_timeout", 32'(k), 32'd5);
        break;
      end
    end
    low_cnt = k;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;
    mem[2] = 16'h5678; mem[3] = 16'h1234;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_stall", stall_cycles, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
    end
    check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
    check("idle_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("idle_rdata", rdata, 32'd0);
    @(posedge clk); #1;

    // 2: store DEADBEEF at 1024; trace index 0 is the IDLE cycle holding the request
    do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0);
    check("st_low_cycles", 32'(low_cnt), 32'(2*WC+1));
    for (int k = 1; k <= 2; k++) begin
      check("st_lo_addr", 32'(tr_addr[k]), 32'd0);
      check("st_lo_dq", {16'd0, tr_dq[k]}, 32'h0000BEEF);
      check("st_lo_wen", {31'd0, tr_wen[k]}, 32'd0);
    end
    for (int k = 3; k <= 4; k++) begin
      check("st_hi_addr", 32'(tr_addr[k]), 32'd1);
      check("st_hi_dq", {16'd0, tr_dq[k]}, 32'h0000DEAD);
      check("st_hi_wen", {31'd0, tr_wen[k]}, 32'd0);
    end
    check("st_done_wen", {31'd0, tr_wen[5]}, 32'd1);
    @(negedge clk);
    check("st_after_ready", {31'd0, ready}, 32'd1);
    check("st_after_wen", {31'd0, sram_we_n}, 32'd1);
    check("mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    check("mem1", {16'd0, mem[1]}, 32'h0000DEAD);
    @(posedge clk); #1;

    // 3: load from 1028, then a store that must not disturb rdata
    do_access(1'b0, 1'b1, 32'd1028, 32'h0, 32'h12345678);
    check("ld_low_cycles", 32'(low_cnt), 32'(2*WC+1));
    do_access(1'b1, 1'b0, 32'd1040, 32'hA5A5A5A5, 32'h12345678);
    check("ld_hold_rdata", rdata, 32'h12345678);

    // 4: back-to-back store/load at 2048
    do_access(1'b1, 1'b0, 32'd2048, 32'hCAFEF00D, 32'h12345678);
    check("b2b_st_a0", 32'(tr_addr[1]), 32'd512);
    check("b2b_st_a1", 32'(tr_addr[3]), 32'd513);
    do_access(1'b0, 1'b1, 32'd2048, 32'h0, 32'hCAFEF00D);
    check("b2b_ld_cycles", 32'(low_cnt), 32'(2*WC+1));
    check("b2b_ld_a0", 32'(tr_addr[1]), 32'd512);
    check("b2b_ld_a1", 32'(tr_addr[3]), 32'd513);

    // 5: both enables -> write wins
    do_access(1'b1, 1'b1, 32'd1032, 32'h11112222, 32'hCAFEF00D);
    @(negedge clk);
    check("both_mem4", {16'd0, mem[4]}, 32'h00002222);
    check("both_mem5", {16'd0, mem[5]}, 32'h00001111);
    check("both_rdata", rdata, 32'hCAFEF00D);
    @(posedge clk); #1;

    // 6: reset during the HIGH phase of a store
    wr_en = 1'b1; address = 32'd1048; wdata = 32'h0BADF00D;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    wr_en = 1'b0;
    @(negedge clk);
    check("abort_stall", stall_cycles, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF);
`ifdef MEM_SRAM_STALL_CNT_EN
    check("stall_one_access", stall_cycles, 32'(2*WC+1));
`else
    check("stall_tied_zero", stall_cycles, 32'd0);
`endif
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
